// File: rtl/floating_point_adder_data_path.sv
// Two-stage IEEE-754 binary32 adder: stage 1 unpacks, orders, aligns and adds;
// stage 2 normalizes, rounds to nearest-even and packs. Denormals flush to zero.
module floating_point_adder_data_path (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  output logic [31:0] out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------- stage 1: unpack, compare, swap, align, add ----------------
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [30:0] a_mag, b_mag, big_mag, small_mag;
  logic        swap, eff_sub, big_sign;
  logic [23:0] big_man, small_man;
  logic [7:0]  shift_amt;
  logic [26:0] big_ext, small_ext, small_al, sticky_mask;
  logic        spec_d, sign_d, v1_q, spec1_q, sign1_q;
  logic [31:0] spec_val_d, spec_val1_q;
  logic [27:0] sum_d, sum1_q;
  logic [7:0]  exp1_q;

  assign a_zero = (in1[30:23] == 8'd0);
  assign b_zero = (in2[30:23] == 8'd0);
  assign a_inf  = (&in1[30:23]) && (in1[22:0] == 23'd0);
  assign b_inf  = (&in2[30:23]) && (in2[22:0] == 23'd0);
  assign a_nan  = (&in1[30:23]) && (in1[22:0] != 23'd0);
  assign b_nan  = (&in2[30:23]) && (in2[22:0] != 23'd0);

  assign a_mag     = a_zero ? 31'd0 : in1[30:0];
  assign b_mag     = b_zero ? 31'd0 : in2[30:0];
  assign swap      = (b_mag > a_mag);
  assign big_mag   = swap ? b_mag : a_mag;
  assign small_mag = swap ? a_mag : b_mag;
  assign big_sign  = swap ? in2[31] : in1[31];
  assign eff_sub   = in1[31] ^ in2[31];

  assign big_man     = {big_mag[30:23] != 8'd0, big_mag[22:0]};
  assign small_man   = {small_mag[30:23] != 8'd0, small_mag[22:0]};
  assign shift_amt   = big_mag[30:23] - small_mag[30:23];
  assign big_ext     = {big_man, 3'b000};
  assign small_ext   = {small_man, 3'b000};
  assign sticky_mask = (27'd1 << shift_amt) - 27'd1;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    small_al   = {26'd0, |small_man};
    spec_d     = 1'b0;
    spec_val_d = QNAN;
    if (shift_amt < 8'd26)
      small_al = (small_ext >> shift_amt) | {26'd0, |(small_ext & sticky_mask)};
    sum_d = eff_sub ? ({1'b0, big_ext} - {1'b0, small_al})
                    : ({1'b0, big_ext} + {1'b0, small_al});
    // Exact cancellation is always +0; same-signed zeros keep their sign.
    sign_d = (eff_sub && (a_mag == b_mag)) ? 1'b0 : big_sign;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      spec_d     = 1'b1;
      spec_val_d = QNAN;
    end else if (a_inf) begin
      spec_d     = 1'b1;
      spec_val_d = in1;
    end else if (b_inf) begin
      spec_d     = 1'b1;
      spec_val_d = in2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      spec1_q     <= 1'b0;
      spec_val1_q <= 32'd0;
      sign1_q     <= 1'b0;
      exp1_q      <= 8'd0;
      sum1_q      <= 28'd0;
    end else begin
      v1_q        <= in_valid;
      spec1_q     <= spec_d;
      spec_val1_q <= spec_val_d;
      sign1_q     <= sign_d;
      exp1_q      <= big_mag[30:23];
      sum1_q      <= sum_d;
    end
  end

  // ---------------- stage 2: normalize, round, pack ----------------
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_f;
  logic              round_up;
  logic [24:0]       mant_r;
  logic [23:0]       mant_f;
  logic [31:0]       res_d, out_q;
  logic              out_valid_q;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum1_q[i]) lz = 5'(26 - i);
    if (sum1_q[27]) begin
      norm  = {sum1_q[27:2], sum1_q[1] | sum1_q[0]};
      exp_n = $signed({2'b00, exp1_q}) + 10'sd1;
    end else begin
      norm  = sum1_q[26:0] << lz;
      exp_n = $signed({2'b00, exp1_q}) - $signed({5'b00000, lz});
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    mant_f   = mant_r[24] ? mant_r[24:1] : mant_r[23:0];
    exp_f    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
    if (spec1_q)
      res_d = spec_val1_q;
    else if (sum1_q == 28'd0 || exp_f < 10'sd1)
      res_d = {sign1_q, 31'd0};
    else if (exp_f >= 10'sd255)
      res_d = {sign1_q, 8'hFF, 23'd0};
    else
      res_d = {sign1_q, exp_f[7:0], mant_f[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= 32'd0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) out_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_floating_point_adder_data_path.sv
// Directed bench for the binary32 adder pipeline: expected sums are queued when
// each pair is driven and compared when out_valid rises two edges later.
module tb_floating_point_adder_data_path;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        out_valid;
  logic [31:0] out;

  floating_point_adder_data_path dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [31:0]   sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Monitor: reference valid pipe and hold-value model, scoreboard pop.
  logic        vp0 = 1'b0, vp1 = 1'b0, m_acc, m_rst;
  logic [31:0] last_out = 32'd0, m_exp;
  always @(posedge clk) begin
    m_acc = in_valid && !rst;
    m_rst = rst;
    #1;
    vp1 = m_rst ? 1'b0 : vp0;
    vp0 = m_acc;
    if (m_rst) last_out = 32'd0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, vp1});
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out, 32'hxxxx_xxxx);
      end else begin
        m_exp = sb.pop_front();
        chk("sum", out, m_exp);
        last_out = m_exp;
      end
    end else begin
      chk("hold", out, last_out);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    in1 = a; in2 = b; in_valid = 1'b1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in1 = $urandom; in2 = $urandom;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out", out, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back directed pairs
    send(32'h3F99999A, 32'h00000000, 32'h3F99999A); // x + 0
    send(32'h00000000, 32'h3F99999A, 32'h3F99999A); // 0 + x
    send(32'h3F99999A, 32'h3E4CCCCD, 32'h3FB33334); // 1.2 + 0.2
    send(32'h3E4CCCCD, 32'h3F99999A, 32'h3FB33334); // swapped
    send(32'hBF99999A, 32'h3ECCCCCD, 32'hBF4CCCCE); // -1.2 + 0.4
    send(32'h40400000, 32'hC0400000, 32'h00000000); // exact cancel
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000); // overflow -> inf
    send(32'h7F800000, 32'hFF800000, 32'h7FC00000); // inf - inf
    send(32'h3F800000, 32'h3F800000, 32'h40000000); // 1 + 1 carry-out
    send(32'h80000000, 32'h80000000, 32'h80000000); // -0 + -0
    send(32'h00000000, 32'h80000000, 32'h00000000); // +0 + -0
    send(32'h7F800001, 32'h3F800000, 32'h7FC00000); // NaN in
    send(32'hFF800000, 32'h3F800000, 32'hFF800000); // -inf + finite
    send(32'h00000001, 32'h3F800000, 32'h3F800000); // denormal flushed
    idle(1);
    send(32'h3F800000, 32'hBF000000, 32'h3F000000); // 1 - 0.5 cancellation
    send(32'h40000000, 32'h3F800000, 32'h40400000); // 2 + 1
    send(32'h3F800000, 32'h33800000, 32'h3F800000); // tie, even stays
    send(32'h3F800001, 32'h33800000, 32'h3F800002); // tie, odd rounds up
    send(32'h00800000, 32'h80800001, 32'h80000000); // underflow -> -0
    send(32'h3F800000, 32'h4B800000, 32'h4B800000); // tiny addend, shift 24
    idle(3);

    // Reset with pairs in flight; rst beats in_valid in the same cycle
    send(32'h3F800000, 32'h3F800000, 32'h40000000);
    send(32'h40000000, 32'h40000000, 32'h40800000);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in1 = 32'h3F800000; in2 = 32'h3F800000;
    sb.delete();
    @(posedge clk);
    #2;
    chk("midrst_out", out, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    idle(3);

    // Recovery after reset
    send(32'h40400000, 32'h3F800000, 32'h40800000); // 3 + 1
    send(32'hC0400000, 32'h3F800000, 32'hC0000000); // -3 + 1
    idle(1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #3;
    chk("drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
